// File: rtl/lfsr_pkg.sv
// lfsr_pkg: polynomial definition and state encoding shared by the PRBS generator and checker
package lfsr_pkg;
  localparam int LFSR_W = 26;
  localparam int TAP_A  = 26;
  localparam int TAP_B  = 8;
  localparam int TAP_C  = 7;
  localparam int TAP_D  = 1;
  typedef enum logic [1:0] {SEED = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;
  // Bit 0 holds w[1] (newest), bit LFSR_W-1 holds w[26] (oldest)
  function automatic logic prbs_bit(input logic [LFSR_W-1:0] w);
    return w[TAP_A-1] ^ w[TAP_B-1] ^ w[TAP_C-1] ^ w[TAP_D-1];
  endfunction
endpackage

// File: rtl/prbs_window.sv
// prbs_window: 26-bit history of received bits with next-bit prediction and all-zero flag
module prbs_window
  import lfsr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sel_pb,
  input  logic din,
  output logic pb,
  output logic all_zero
);
  logic [LFSR_W-1:0] w_q, w_d;
  always_comb w_d = en ? {w_q[LFSR_W-2:0], sel_pb ? pb : din} : w_q;
  always_ff @(posedge clk) w_q <= rst ? '0 : w_d;
  assign pb       = prbs_bit(w_q);
  assign all_zero = ~|w_q;
endmodule

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: self-synchronising PRBS26 checker with lock detection and error counting
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT  = 32,
  parameter int LOSS_WIN  = 128,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 16
) (
  input  logic             p_clk_in,
  input  logic             p_rst,
  input  logic             p_din_valid,
  input  logic             p_din,
  input  logic             p_clear,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);
  localparam int SW = $clog2(LFSR_W + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(LOSS_WIN + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);
  state_t state_q, state_d;
  logic [SW-1:0] seed_cnt_q, seed_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_errs_q, win_errs_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic err_q, err_d, lock_q, lock_d;
  logic pb, all_zero, locked, miss, win_end;
  assign locked  = state_q == LOCKED;
  assign miss    = p_din ^ pb;
  assign win_end = win_cnt_q == WW'(LOSS_WIN - 1);
  // Once locked the window follows its own prediction, so a channel error never propagates
  prbs_window u_win (
    .clk      (p_clk_in),
    .rst      (p_rst),
    .en       (p_din_valid),
    .sel_pb   (locked),
    .din      (p_din),
    .pb       (pb),
    .all_zero (all_zero)
  );
  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_errs_d  = win_errs_q;
    err_d       = p_din_valid && locked && miss;
    err_cnt_d   = p_clear ? '0 : (err_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    if (p_din_valid) begin
      if (state_q == SEED) begin
        seed_cnt_d = seed_cnt_q + 1'b1;
        if (seed_cnt_q == SW'(LFSR_W - 1)) begin
          state_d     = CHECK;
          match_cnt_d = '0;
        end
      end else if (state_q == CHECK) begin
        match_cnt_d = (miss || all_zero) ? '0 : match_cnt_q + 1'b1;
        if (!miss && !all_zero && match_cnt_q == MW'(LOCK_CNT - 1)) state_d = LOCKED;
      end else if (locked) begin
        win_cnt_d  = win_end ? '0 : win_cnt_q + 1'b1;
        win_errs_d = win_end ? '0 : win_errs_q + EW'(miss);
        // Loss beats a same-edge window rollover
        if (miss && win_errs_q == EW'(LOSS_ERRS - 1)) begin
          state_d    = SEED;
          seed_cnt_d = '0;
          win_cnt_d  = '0;
          win_errs_d = '0;
        end
      end else begin
        state_d    = SEED;
        seed_cnt_d = '0;
      end
    end
    lock_d = state_d == LOCKED;
  end
  always_ff @(posedge p_clk_in) begin
    if (p_rst) begin
      state_q     <= SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_errs_q  <= win_errs_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      lock_q      <= lock_d;
    end
  end
  assign o_lock    = lock_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
endmodule
